alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Front-end controller for the board-level ALU.
- Turns a single switch bank plus three push buttons into an ordered load of operand A, operand B and opcode.
- Drives the combinational ALU inputs from registers, captures the ALU result one cycle after the opcode is committed, and holds it on the LEDs.
- Rejects unsupported opcodes with an error flag, so the ALU never sees an illegal operation.

Parameters:
- NB_DATA, 8, width of switch bank, operands, ALU result and LED bus.
- NB_OP, 6, opcode width; taken from i_sw[NB_OP-1:0]; must satisfy NB_OP <= NB_DATA.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst_n  input  1  synchronous, active-low reset.
- i_sw  input  NB_DATA  switch bank; asynchronous to the clock, sampled only on a commit.
- i_btn  input  3  raw push buttons: [0] commit A, [1] commit B, [2] commit OP; asynchronous.
- i_alu_res  input  NB_DATA  combinational result returned by the ALU.
- o_A  output  NB_DATA  registered operand A to the ALU.
- o_B  output  NB_DATA  registered operand B to the ALU.
- o_OP  output  NB_OP  registered opcode to the ALU.
- o_led  output  NB_DATA  registered, held ALU result.
- o_state  output  3  current FSM state encoding, for debug LEDs.
- o_err  output  1  sticky invalid-opcode flag.

Behaviour:
- Reset: while i_rst_n=0 at a rising edge, o_A, o_B, o_OP, o_led, o_err <= 0; state <= S_A; all synchronizer and edge flops <= 0. Reset wins over any button event in the same cycle.
- Button conditioning, per bit:
  - 2-flop synchronizer (s1, s2), then edge register s2_d.
  - pulse = s2 & ~s2_d, exactly one cycle wide per press; a held button gives one pulse only.
  - Button rises before edge 0: s1 at edge 0, s2 at edge 1, pulse high between edges 1 and 2, action registered at edge 2.
  - Button-to-register latency is therefore 3 rising edges.
- FSM states: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4. Encodings 5-7 are unreachable; if entered, go to S_A next cycle.
- S_A: pulse[0] -> o_A <= i_sw, go S_B. Other pulses ignored.
- S_B: pulse[1] -> o_B <= i_sw, go S_OP. Other pulses ignored.
- S_OP: pulse[2] with i_sw[NB_OP-1:0] in the valid set:
  - Valid set: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010.
  - o_OP <= code, o_err <= 0, go S_EXEC.
- S_OP: pulse[2] with an invalid code -> o_OP unchanged, o_err <= 1, stay in S_OP.
- S_EXEC: lasts exactly one cycle; unconditionally o_led <= i_alu_res, go S_SHOW. All pulses are ignored in this cycle.
- S_SHOW: o_led, o_A, o_B, o_OP held. pulse[0] -> o_A <= i_sw, go S_B, starting a new operation. o_led keeps the old result until the next S_EXEC.
- Simultaneous pulses: only the button designated for the current state acts; the rest are discarded, not queued.
- o_err stays 1 until a valid opcode commit or reset.
- Result latency: from the S_OP commit edge to o_led update is 1 edge (the S_EXEC exit edge).
- Reset mid-operation returns to S_A and clears o_led; partially loaded operands are lost.
- o_state = state register; o_state=0 directly after reset.

Test Plan:
- Reset, then: sw=0x05 + btn0; sw=0x03 + btn1; sw=0x20 + btn2 -> o_A=0x05, o_B=0x03, o_OP=0x20; o_led=0x08 one edge after the OP commit; o_state=4.
- Reset check: assert i_rst_n=0 with btn0 held, release -> o_A=0, o_led=0, o_state=0. Button still held after release -> exactly one load of A.
- Invalid opcode: in S_OP, sw=0x3F + btn2 -> o_err=1, o_state=2, o_OP unchanged. Then sw=0x22 + btn2 -> o_err=0, o_OP=0x22.
- Wrong/simultaneous buttons: in S_A, press btn1 and btn2 -> no state or register change. Press btn0 and btn1 together -> only o_A loads, state goes to S_B.
- Held button: btn0 high for 20 cycles in S_A -> one pulse, o_A loads once, state=S_B and stays there.
- Back-to-back ops: from S_SHOW with o_led=0x08, load A=0xF0, B=0x0F, OP=0x26 -> o_led stays 0x08 through loading, then becomes 0xFF. Assert reset in S_OP -> o_state=0, o_led=0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Front-end sequencer for the board ALU: conditions three push buttons and loads
// operand A, operand B and opcode in order, then latches the ALU result onto the LEDs.
module alu_op_sequencer #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_sw,
    input  logic [2:0]         i_btn,
    input  logic [NB_DATA-1:0] i_alu_res,
    output logic [NB_DATA-1:0] o_A,
    output logic [NB_DATA-1:0] o_B,
    output logic [NB_OP-1:0]   o_OP,
    output logic [NB_DATA-1:0] o_led,
    output logic [2:0]         o_state,
    output logic               o_err
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

    function automatic logic op_valid(input logic [NB_OP-1:0] code);
        case (code)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    logic [2:0]         sync1_q, sync2_q, edge_q;
    logic [2:0]         btn_pulse;
    logic [NB_OP-1:0]   sw_op;
    state_t             state_q;
    logic [NB_DATA-1:0] a_q, b_q, led_q;
    logic [NB_OP-1:0]   op_q;
    logic               err_q;

    // Two-flop synchronizer plus one edge flop: a held button yields a single pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            edge_q  <= '0;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    assign btn_pulse = sync2_q & ~edge_q;
    assign sw_op     = i_sw[NB_OP-1:0];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            led_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_A: begin
                    if (btn_pulse[0]) begin
                        a_q     <= i_sw;
                        state_q <= S_B;
                    end
                end
                S_B: begin
                    if (btn_pulse[1]) begin
                        b_q     <= i_sw;
                        state_q <= S_OP;
                    end
                end
                S_OP: begin
                    // Illegal codes never reach the ALU; the last good opcode stays applied.
                    if (btn_pulse[2]) begin
                        if (op_valid(sw_op)) begin
                            op_q    <= sw_op;
                            err_q   <= 1'b0;
                            state_q <= S_EXEC;
                        end else begin
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    led_q   <= i_alu_res;
                    state_q <= S_SHOW;
                end
                S_SHOW: begin
                    if (btn_pulse[0]) begin
                        a_q     <= i_sw;
                        state_q <= S_B;
                    end
                end
                default: state_q <= S_A;
            endcase
        end
    end

    assign o_A     = a_q;
    assign o_B     = b_q;
    assign o_OP    = op_q;
    assign o_led   = led_q;
    assign o_state = state_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios plus random button/switch
// sequences checked against an operation-level model of the sequencer.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw = '0;
    logic [2:0] btn = '0;
    logic [7:0] alu_res;
    logic [7:0] o_A, o_B, o_led;
    logic [5:0] o_OP;
    logic [2:0] o_state;
    logic       o_err;

    int checks = 0;
    int errors = 0;

    // Model: operation-level view, one update per button press.
    logic [7:0] m_a, m_b, m_led;
    logic [5:0] m_op;
    logic       m_err;
    int         m_st;

    always #5 clk = ~clk;

    alu_op_sequencer #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sw(sw), .i_btn(btn), .i_alu_res(alu_res),
        .o_A(o_A), .o_B(o_B), .o_OP(o_OP), .o_led(o_led), .o_state(o_state), .o_err(o_err)
    );

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return 8'($signed(a) >>> b);
            6'h02:   return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    always_comb alu_res = alu_f(o_A, o_B, o_OP);

    function automatic logic legal(input logic [5:0] c);
        return c inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
    endfunction

    task automatic model_reset();
        m_a = '0; m_b = '0; m_op = '0; m_led = '0; m_err = 1'b0; m_st = 0;
    endtask

    task automatic model_press(input logic [2:0] m, input logic [7:0] s);
        if ((m_st == 0 || m_st == 4) && m[0]) begin
            m_a = s; m_st = 1;
        end else if (m_st == 1 && m[1]) begin
            m_b = s; m_st = 2;
        end else if (m_st == 2 && m[2]) begin
            if (legal(s[5:0])) begin
                m_op = s[5:0]; m_err = 1'b0; m_led = alu_f(m_a, m_b, m_op); m_st = 4;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; btn = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Hold the mask for 'hold' cycles, release, then let the pipeline drain.
    task automatic press(input logic [2:0] m, input logic [7:0] s, input int hold);
        @(negedge clk);
        sw = s; btn = m;
        repeat (hold) @(negedge clk);
        btn = '0;
        repeat (5) @(negedge clk);
        model_press(m, s);
    endtask

    task automatic test_basic();
        do_reset();
        if (o_A !== 8'h00 || o_B !== 8'h00 || o_OP !== 6'h00 || o_led !== 8'h00 || o_state !== 3'd0 || o_err !== 1'b0) begin
            errors++; $display("FAIL reset_state: A=%h B=%h OP=%h led=%h st=%0d err=%b want all 0", o_A, o_B, o_OP, o_led, o_state, o_err);
        end
        checks++;
        @(negedge clk); sw = 8'h05; btn = 3'b001;
        repeat (2) @(negedge clk);
        if (o_A !== 8'h00 || o_state !== 3'd0) begin
            errors++; $display("FAIL latency_early: A=%h st=%0d want 00/0", o_A, o_state);
        end
        checks++;
        @(negedge clk);
        if (o_A !== 8'h05 || o_state !== 3'd1) begin
            errors++; $display("FAIL latency_loadA: A=%h st=%0d want 05/1", o_A, o_state);
        end
        checks++;
        btn = '0;
        repeat (3) @(negedge clk);
        model_press(3'b001, 8'h05);
        press(3'b010, 8'h03, 1);
        if (o_B !== 8'h03 || o_state !== 3'd2) begin
            errors++; $display("FAIL loadB: B=%h st=%0d want 03/2", o_B, o_state);
        end
        checks++;
        @(negedge clk); sw = 8'h20; btn = 3'b100;
        repeat (3) @(negedge clk);
        if (o_OP !== 6'h20 || o_state !== 3'd3 || o_led !== 8'h00) begin
            errors++; $display("FAIL op_commit: OP=%h st=%0d led=%h want 20/3/00", o_OP, o_state, o_led);
        end
        checks++;
        @(negedge clk);
        if (o_led !== 8'h08 || o_state !== 3'd4) begin
            errors++; $display("FAIL result: led=%h st=%0d want 08/4", o_led, o_state);
        end
        checks++;
        btn = '0;
        repeat (3) @(negedge clk);
        model_press(3'b100, 8'h20);
    endtask

    task automatic test_back_to_back();
        press(3'b001, 8'hF0, 2);
        if (o_led !== 8'h08 || o_A !== 8'hF0 || o_state !== 3'd1) begin
            errors++; $display("FAIL b2b_A: led=%h A=%h st=%0d want 08/F0/1", o_led, o_A, o_state);
        end
        checks++;
        press(3'b010, 8'h0F, 2);
        if (o_led !== 8'h08 || o_B !== 8'h0F) begin
            errors++; $display("FAIL b2b_B: led=%h B=%h want 08/0F", o_led, o_B);
        end
        checks++;
        press(3'b100, 8'h26, 2);
        if (o_led !== 8'hFF || o_OP !== 6'h26 || o_state !== 3'd4) begin
            errors++; $display("FAIL b2b_res: led=%h OP=%h st=%0d want FF/26/4", o_led, o_OP, o_state);
        end
        checks++;
        press(3'b001, 8'h11, 1);
        press(3'b010, 8'h22, 1);
        if (o_state !== 3'd2) begin
            errors++; $display("FAIL b2b_inop: st=%0d want 2", o_state);
        end
        checks++;
        do_reset();
        if (o_state !== 3'd0 || o_led !== 8'h00 || o_A !== 8'h00) begin
            errors++; $display("FAIL midop_reset: st=%0d led=%h A=%h want 0/00/00", o_state, o_led, o_A);
        end
        checks++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; sw = 8'h55; btn = 3'b001;
        repeat (4) @(negedge clk);
        if (o_A !== 8'h00 || o_led !== 8'h00 || o_state !== 3'd0 || o_err !== 1'b0) begin
            errors++; $display("FAIL reset_held_btn: A=%h led=%h st=%0d err=%b want 00/00/0/0", o_A, o_led, o_state, o_err);
        end
        checks++;
        rst_n = 1'b1;
        model_reset();
        repeat (10) @(negedge clk);
        sw = 8'h66;
        repeat (5) @(negedge clk);
        btn = '0;
        repeat (4) @(negedge clk);
        model_press(3'b001, 8'h55);
        if (o_A !== m_a || o_state !== 3'(m_st)) begin
            errors++; $display("FAIL reset_release_load: A=%h st=%0d want %h/%0d", o_A, o_state, m_a, m_st);
        end
        checks++;
    endtask

    task automatic test_held();
        do_reset();
        @(negedge clk); sw = 8'h3C; btn = 3'b001;
        repeat (6) @(negedge clk);
        sw = 8'hC3;
        repeat (14) @(negedge clk);
        btn = '0;
        repeat (4) @(negedge clk);
        model_press(3'b001, 8'h3C);
        if (o_A !== 8'h3C || o_state !== 3'd1) begin
            errors++; $display("FAIL held_once: A=%h st=%0d want 3C/1", o_A, o_state);
        end
        checks++;
        press(3'b001, 8'h99, 1);
        if (o_A !== 8'h3C || o_state !== 3'd1) begin
            errors++; $display("FAIL btn0_in_B: A=%h st=%0d want 3C/1", o_A, o_state);
        end
        checks++;
    endtask

    task automatic test_wrong_buttons();
        do_reset();
        press(3'b110, 8'h77, 2);
        if (o_A !== 8'h00 || o_B !== 8'h00 || o_OP !== 6'h00 || o_state !== 3'd0) begin
            errors++; $display("FAIL wrong_btn: A=%h B=%h OP=%h st=%0d want 00/00/00/0", o_A, o_B, o_OP, o_state);
        end
        checks++;
        press(3'b011, 8'h5A, 2);
        if (o_A !== 8'h5A || o_B !== 8'h00 || o_state !== 3'd1) begin
            errors++; $display("FAIL simul_btn: A=%h B=%h st=%0d want 5A/00/1", o_A, o_B, o_state);
        end
        checks++;
    endtask

    task automatic test_invalid_op();
        do_reset();
        press(3'b001, 8'h11, 1);
        press(3'b010, 8'h22, 1);
        press(3'b100, 8'h3F, 1);
        if (o_err !== 1'b1 || o_state !== 3'd2 || o_OP !== 6'h00) begin
            errors++; $display("FAIL invalid_op: err=%b st=%0d OP=%h want 1/2/00", o_err, o_state, o_OP);
        end
        checks++;
        press(3'b100, 8'h22, 1);
        if (o_err !== 1'b0 || o_OP !== 6'h22 || o_led !== 8'hEF || o_state !== 3'd4) begin
            errors++; $display("FAIL recover_op: err=%b OP=%h led=%h st=%0d want 0/22/EF/4", o_err, o_OP, o_led, o_state);
        end
        checks++;
    endtask

    task automatic test_random();
        logic [5:0] vcodes [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
        logic [2:0] m;
        logic [7:0] s;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            m = 3'($urandom_range(1, 7));
            s = 8'($urandom);
            if (m[2] && $urandom_range(0, 3) != 0)
                s = {s[7:6], vcodes[$urandom_range(0, 7)]};
            press(m, s, $urandom_range(1, 4));
            if (o_A !== m_a || o_B !== m_b || o_OP !== m_op || o_led !== m_led || o_err !== m_err || o_state !== 3'(m_st)) begin
                errors++;
                $display("FAIL rand[%0d]: A=%h B=%h OP=%h led=%h err=%b st=%0d want %h/%h/%h/%h/%b/%0d",
                         i, o_A, o_B, o_OP, o_led, o_err, o_state, m_a, m_b, m_op, m_led, m_err, m_st);
            end
            checks++;
        end
    endtask

    initial begin
        model_reset();
        test_basic();
        test_back_to_back();
        test_reset();
        test_held();
        test_wrong_buttons();
        test_invalid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
